// File: rtl/qgate_pkg.sv
// Shared types, fixed-point constants and helpers for the single-qubit gate sequencer.
// Amplitudes are signed Q(W-FRAC).FRAC values with an implicit scale of SCALE_FACTOR.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef SCALE_FACTOR
`define SCALE_FACTOR 16384
`endif
`ifndef FIXED_POINT_CONST_1
`define FIXED_POINT_CONST_1 16384
`endif

package qgate_pkg;
    localparam int W    = `FIXED_WIDTH;
    localparam int FRAC = $clog2(`SCALE_FACTOR);

    localparam logic signed [W-1:0] ONE       = W'(`FIXED_POINT_CONST_1);
    localparam logic signed [W-1:0] INV_SQRT2 =
        W'($rtoi(real'(`SCALE_FACTOR) * 0.7071067811865476 + 0.5));
    localparam logic signed [W-1:0] AMP_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] AMP_MIN   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_I   = 3'd0,
        OP_X   = 3'd1,
        OP_Y   = 3'd2,
        OP_Z   = 3'd3,
        OP_S   = 3'd4,
        OP_SDG = 3'd5,
        OP_H   = 3'd6,
        OP_RSV = 3'd7
    } op_t;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic last;
        op_t  code;
    } op_entry_t;

    // Two's-complement negation that clips -MIN to MAX instead of wrapping.
    function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] x);
        return (x == AMP_MIN) ? AMP_MAX : -x;
    endfunction
endpackage

// File: rtl/qubit_gate_sequencer_if.sv
// Host-side bundle: state load, opcode stream and final-state readout handshakes.
interface qubit_gate_sequencer_if;
    import qgate_pkg::*;

    logic  load_valid;
    logic  load_ready;
    cplx_t load_a;
    cplx_t load_b;
    logic  op_valid;
    logic  op_ready;
    op_t   op_code;
    logic  op_last;
    logic  out_valid;
    logic  out_ready;
    cplx_t out_a;
    cplx_t out_b;

    modport master (
        output load_valid, load_a, load_b, op_valid, op_code, op_last, out_ready,
        input  load_ready, op_ready, out_valid, out_a, out_b
    );

    modport slave (
        input  load_valid, load_a, load_b, op_valid, op_code, op_last, out_ready,
        output load_ready, op_ready, out_valid, out_a, out_b
    );
endinterface

// File: rtl/op_fifo.sv
// Synchronous show-ahead FIFO for {last, code} opcode entries.
// Pushes while full are dropped; pops while empty are ignored.
module op_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/qubit_gate_sequencer.sv
// Applies a buffered stream of single-qubit gates to one (alpha, beta) state and
// presents the result on a valid/ready port; H takes an extra cycle for the 1/sqrt2 scale.
module qubit_gate_sequencer
    import qgate_pkg::*;
#(
    parameter int OP_FIFO_DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    qubit_gate_sequencer_if.slave  bus,
    output logic                   o_busy,
    output logic                   o_err_illegal_op
);
    localparam int PW = 2*W + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RUN_H2, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    cplx_t               r_a;
    cplx_t               r_b;
    cplx_t               w_ga;
    cplx_t               w_gb;
    logic signed [W:0]   r_hs_re;
    logic signed [W:0]   r_hs_im;
    logic signed [W:0]   r_hd_re;
    logic signed [W:0]   r_hd_im;
    logic                r_h_last;
    logic                r_err;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [3:0]          w_fifo_rd;
    op_entry_t           w_entry;

    op_fifo #(.DEPTH(OP_FIFO_DEPTH), .WIDTH(4)) u_op_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (bus.op_valid),
        .i_data  ({bus.op_last, bus.op_code}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rd),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_entry = op_entry_t'(w_fifo_rd);

    // round(x * INV_SQRT2 / 2^FRAC) with half-LSB bias, then clip to the amplitude range.
    function automatic logic signed [W-1:0] h_scale(input logic signed [W:0] x);
        logic signed [PW-1:0] p;
        p = PW'(x) * PW'(INV_SQRT2) + (PW'(1) <<< (FRAC-1));
        p = p >>> FRAC;
        if (p > PW'(AMP_MAX)) return AMP_MAX;
        if (p < PW'(AMP_MIN)) return AMP_MIN;
        return p[W-1:0];
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_pop          = 1'b0;
        bus.load_ready = (r_state == S_IDLE);
        bus.out_valid  = (r_state == S_DONE);
        o_busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   if (bus.load_valid) w_next = S_RUN;
            S_RUN: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_entry.code == OP_H) w_next = S_RUN_H2;
                    else if (w_entry.last)    w_next = S_DONE;
                end
            end
            S_RUN_H2: w_next = r_h_last ? S_DONE : S_RUN;
            S_DONE:   if (bus.out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Non-H gate results for the entry at the FIFO head.
    always_comb begin
        w_ga = r_a;
        w_gb = r_b;
        case (w_entry.code)
            OP_X: begin
                w_ga = r_b;
                w_gb = r_a;
            end
            OP_Y: begin
                w_ga.re = r_b.im;
                w_ga.im = sat_neg(r_b.re);
                w_gb.re = sat_neg(r_a.im);
                w_gb.im = r_a.re;
            end
            OP_Z: begin
                w_gb.re = sat_neg(r_b.re);
                w_gb.im = sat_neg(r_b.im);
            end
            OP_S: begin
                w_gb.re = sat_neg(r_b.im);
                w_gb.im = r_b.re;
            end
            OP_SDG: begin
                w_gb.re = r_b.im;
                w_gb.im = sat_neg(r_b.re);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_hs_re  <= '0;
            r_hs_im  <= '0;
            r_hd_re  <= '0;
            r_hd_im  <= '0;
            r_h_last <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.load_valid) begin
                        r_a   <= bus.load_a;
                        r_b   <= bus.load_b;
                        r_err <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!w_empty) begin
                        if (w_entry.code == OP_H) begin
                            r_hs_re  <= {r_a.re[W-1], r_a.re} + {r_b.re[W-1], r_b.re};
                            r_hs_im  <= {r_a.im[W-1], r_a.im} + {r_b.im[W-1], r_b.im};
                            r_hd_re  <= {r_a.re[W-1], r_a.re} - {r_b.re[W-1], r_b.re};
                            r_hd_im  <= {r_a.im[W-1], r_a.im} - {r_b.im[W-1], r_b.im};
                            r_h_last <= w_entry.last;
                        end else begin
                            r_a <= w_ga;
                            r_b <= w_gb;
                        end
                        if (w_entry.code == OP_RSV) r_err <= 1'b1;
                    end
                end
                S_RUN_H2: begin
                    r_a.re <= h_scale(r_hs_re);
                    r_a.im <= h_scale(r_hs_im);
                    r_b.re <= h_scale(r_hd_re);
                    r_b.im <= h_scale(r_hd_im);
                end
                default: ;
            endcase
        end
    end

    assign bus.op_ready     = !w_full;
    assign bus.out_a        = r_a;
    assign bus.out_b        = r_b;
    assign o_err_illegal_op = r_err;
endmodule

// File: tb/tb_qubit_gate_sequencer.sv
// Directed plus randomized programs checked against an arithmetic gate model and an op queue.
module tb_qubit_gate_sequencer;
    import qgate_pkg::*;

    localparam int     DEPTH  = 8;
    localparam int     FR     = $clog2(`SCALE_FACTOR);
    localparam longint AMAX_L = (longint'(1) <<< (W-1)) - 1;
    localparam longint AMIN_L = -(longint'(1) <<< (W-1));
    localparam longint ONE_L  = `FIXED_POINT_CONST_1;
    localparam longint INV_L  = longint'($rtoi(real'(`SCALE_FACTOR) * 0.7071067811865476 + 0.5));

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err;

    qubit_gate_sequencer_if bus ();

    qubit_gate_sequencer #(.OP_FIFO_DEPTH(DEPTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .bus              (bus),
        .o_busy           (busy),
        .o_err_illegal_op (err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    longint     m [0:3];
    bit         merr;
    logic [3:0] mq [$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sneg(input longint x);
        return (x == AMIN_L) ? AMAX_L : -x;
    endfunction

    function automatic longint hsc(input longint x);
        longint v;
        v = (x * INV_L + (longint'(1) <<< (FR-1))) >>> FR;
        if (v > AMAX_L) v = AMAX_L;
        if (v < AMIN_L) v = AMIN_L;
        return v;
    endfunction

    function automatic void model_op(input int code);
        longint o [0:3];
        o = m;
        case (code)
            1: m = '{o[2], o[3], o[0], o[1]};
            2: m = '{o[3], sneg(o[2]), sneg(o[1]), o[0]};
            3: begin m[2] = sneg(o[2]); m[3] = sneg(o[3]); end
            4: begin m[2] = sneg(o[3]); m[3] = o[2]; end
            5: begin m[2] = o[3]; m[3] = sneg(o[2]); end
            6: m = '{hsc(o[0] + o[2]), hsc(o[1] + o[3]), hsc(o[0] - o[2]), hsc(o[1] - o[3])};
            7: merr = 1'b1;
            default: ;
        endcase
    endfunction

    function automatic longint dut_amp(input int i);
        case (i)
            0:       return longint'($signed(bus.out_a.re));
            1:       return longint'($signed(bus.out_a.im));
            2:       return longint'($signed(bus.out_b.re));
            default: return longint'($signed(bus.out_b.im));
        endcase
    endfunction

    task automatic chk_state(input string tag);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_amp%0d", tag, i), dut_amp(i), m[i]);
    endtask

    // Called right after a negedge; leaves right after the next negedge.
    task automatic push(input int code, input bit last);
        bit exp_rdy;
        exp_rdy        = (mq.size() < DEPTH);
        bus.op_valid   = 1'b1;
        bus.op_code    = op_t'(code);
        bus.op_last    = last;
        chk("op_ready", longint'(bus.op_ready), longint'(exp_rdy));
        if (exp_rdy) mq.push_back({last, 3'(code)});
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic run_prog(input string tag, input longint ar, input longint ai,
                            input longint br, input longint bi, input int hold);
        int         lat;
        int         cnt;
        logic [3:0] e;
        bus.load_valid = 1'b1;
        bus.load_a.re  = W'(ar);
        bus.load_a.im  = W'(ai);
        bus.load_b.re  = W'(br);
        bus.load_b.im  = W'(bi);
        m              = '{ar, ai, br, bi};
        merr           = 1'b0;
        chk({tag, "_load_ready"}, longint'(bus.load_ready), 1);
        @(negedge clk);
        bus.load_valid = 1'b0;
        chk({tag, "_err_clr"}, longint'(err), 0);
        lat = 0;
        while (mq.size() > 0) begin
            e = mq.pop_front();
            lat += (e[2:0] == 3'd6) ? 2 : 1;
            model_op(int'(e[2:0]));
            if (e[3]) break;
        end
        cnt = 0;
        while (!bus.out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_latency"}, cnt, lat);
        chk({tag, "_busy"}, longint'(busy), 1);
        chk({tag, "_err"}, longint'(err), longint'(merr));
        chk_state(tag);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, longint'(bus.out_valid), 1);
            chk_state({tag, "_hold"});
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, longint'(bus.out_valid), 0);
        chk({tag, "_idle"}, longint'(bus.load_ready), 1);
    endtask

    function automatic longint rand_amp();
        case ($urandom_range(0, 5))
            0:       return AMIN_L;
            1:       return AMAX_L;
            2:       return ONE_L;
            3:       return -ONE_L;
            default: return longint'($signed(W'($urandom)));
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.load_valid = 1'b0;
        bus.load_a     = '0;
        bus.load_b     = '0;
        bus.op_valid   = 1'b0;
        bus.op_code    = OP_I;
        bus.op_last    = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_valid", longint'(bus.out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_load_ready", longint'(bus.load_ready), 1);
        chk("rst_op_ready", longint'(bus.op_ready), 1);
        m = '{0, 0, 0, 0};
        chk_state("rst");

        // X swaps the amplitudes
        push(1, 1);
        run_prog("x", ONE_L, 0, 0, 0, 0);
        chk("x_b_re", dut_amp(2), ONE_L);

        // Y on |1> and on |0>
        push(2, 1);
        run_prog("y1", 0, 0, ONE_L, 0, 0);
        chk("y1_a_im", dut_amp(1), -ONE_L);
        push(2, 1);
        run_prog("y0", ONE_L, 0, 0, 0, 0);
        chk("y0_b_im", dut_amp(3), ONE_L);

        // H Z H behaves as X up to rounding
        push(6, 0); push(3, 0); push(6, 1);
        run_prog("hzh", ONE_L, 0, 0, 0, 0);
        chk("hzh_b_re_tol", longint'((dut_amp(2) - ONE_L <= 2) && (ONE_L - dut_amp(2) <= 2)), 1);
        chk("hzh_a_re_tol", longint'((dut_amp(0) <= 2) && (dut_amp(0) >= -2)), 1);

        // S S = Z and S SDG = I
        push(4, 0); push(4, 1);
        run_prog("ss", 0, 0, ONE_L, 0, 0);
        chk("ss_b_re", dut_amp(2), -ONE_L);
        push(4, 0); push(5, 1);
        run_prog("ssdg", 0, 0, ONE_L, 0, 0);
        chk("ssdg_b_re", dut_amp(2), ONE_L);

        // Fill the FIFO past its depth, with an illegal op inside the program
        push(1, 0); push(7, 0); push(3, 0); push(0, 0);
        push(4, 0); push(2, 0); push(5, 0); push(6, 1);
        push(1, 1);
        run_prog("fill", rand_amp(), rand_amp(), rand_amp(), rand_amp(), 5);
        chk("fill_err_set", longint'(err), 1);
        push(1, 1);
        run_prog("after_err", ONE_L, 0, 0, 0, 0);

        // Negating the most negative amplitude saturates
        push(3, 1);
        run_prog("sat", 0, 0, AMIN_L, 0, 0);
        chk("sat_b_re", dut_amp(2), AMAX_L);

        for (int p = 0; p < 25; p++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) push($urandom_range(0, 7), i == n - 1);
            run_prog($sformatf("rnd%0d", p), rand_amp(), rand_amp(), rand_amp(), rand_amp(),
                     $urandom_range(0, 2));
        end

        // Reset in the middle of a program aborts it and flushes the queue
        push(3, 0); push(3, 0); push(3, 0); push(1, 1);
        bus.load_valid = 1'b1;
        bus.load_a.re  = W'(ONE_L);
        bus.load_a.im  = '0;
        bus.load_b.re  = W'(ONE_L);
        bus.load_b.im  = '0;
        @(negedge clk);
        bus.load_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        mq.delete();
        m = '{0, 0, 0, 0};
        chk("mid_rst_valid", longint'(bus.out_valid), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_err", longint'(err), 0);
        chk_state("mid_rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_load_ready", longint'(bus.load_ready), 1);
        chk("post_rst_op_ready", longint'(bus.op_ready), 1);
        bus.load_valid = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_stall_busy", longint'(busy), 1);
        chk("post_rst_stall_valid", longint'(bus.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
